onehot_decoder_pipe: RTL
========================

Name: onehot_decoder_pipe

Overview:
- Parametrised, registered successor to the combinational binary-to-one-hot decoder.
- Accepts a binary index over a valid/ready handshake and returns a decoded vector one cycle later. The vector is one-hot, thermometer or inverted one-hot, selected per transaction.
- Flags indices that fall outside the output width and keeps a saturating count of them.
- Used wherever a registered, flow-controlled select or mask generator is needed, e.g. arbiter grant masks and FIFO slot enables.

Parameters:
- WID, 4, width of the binary index input.
- RESULT_WID, 16, width of the decoded output; legal range 2..2**WID.
- CNT_WID, 8, width of the saturating out-of-range event counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_dat/in_mode are valid this cycle
- in_ready  output  1  block accepts the input this cycle
- in_dat  input  WID  binary index
- in_mode  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 one-hot (reserved, decodes as 00)
- out_valid  output  1  out_result/out_err hold a result
- out_ready  input  1  downstream consumes the result this cycle
- out_result  output  RESULT_WID  decoded vector
- out_err  output  1  the index for this result was >= RESULT_WID
- err_cnt  output  CNT_WID  saturating count of accepted out-of-range indices
- err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk. While rst=1: out_valid=0, out_result=0, out_err=0, err_cnt=0. in_ready follows the combinational rule below; since out_valid=0 under reset, in_ready=1, but no input is captured while rst=1.
- Reset mid-operation: any held result is dropped without being handed off; the first accept after reset deasserts is processed normally.
- Handshake:
  - in_ready = !out_valid || out_ready (single-stage pipe, full throughput, combinational ready path).
  - Input accept: in_valid && in_ready on a rising edge.
  - Output handoff: out_valid && out_ready on a rising edge.
- Latency: exactly 1 cycle from accept to out_valid=1.
- Output register:
  - On accept: load out_result/out_err from the decode of in_dat/in_mode; set out_valid=1.
  - On handoff with no accept in the same cycle: out_valid=0; out_result/out_err hold their last values.
  - Simultaneous handoff and accept: out_valid stays 1 and the new result replaces the old one (back-to-back, no bubble).
- Stall: while out_valid=1 and out_ready=0, out_result/out_err/out_valid are held stable. in_valid may be held high by the source and nothing is lost.
- Decode, with idx = in_dat zero-extended:
  - one-hot: bit idx set, all others 0.
  - thermometer: bits 0..idx set (idx=0 gives 0x...01; idx=RESULT_WID-1 gives all ones).
  - inverted one-hot: bitwise NOT of one-hot.
- Out-of-range (idx >= RESULT_WID; only reachable when RESULT_WID < 2**WID):
  - out_err=1 and out_result=0 in every mode. There is no wrap and no truncation.
  - err_cnt increments by 1 on that accept and saturates at 2**CNT_WID-1.
- err_clr: err_cnt=0 next cycle. If err_clr coincides with an out-of-range accept, the clear wins and err_cnt=0. err_clr has no effect on the data path.
- No state machine beyond the out_valid bit and the counter; no internal state other than the output register and err_cnt.

Decomposition:
- Shared package onehot_pkg holds:
  - mode encodings: MODE_ONEHOT=2'b00, MODE_THERM=2'b01, MODE_INV=2'b10, MODE_RSVD=2'b11;
  - the function decode_vec(idx, mode), returning the decoded vector and the err bit.
- One natural sub-module: onehot_decode_comb (purely combinational decode, parametrised by WID/RESULT_WID), instantiated ahead of the output register. The handshake, output register and counter stay in the top.

Test Plan:
- Reset and basic decode: assert rst for 2 cycles, then check out_valid=0, err_cnt=0, in_ready=1. Then with WID=4, RESULT_WID=16, mode 00, in_dat=5, out_ready=1 -> next cycle out_valid=1, out_result=16'h0020, out_err=0.
- Mode sweep on in_dat=3: mode 01 -> 16'h000F; mode 10 -> 16'hFFF7; mode 11 -> 16'h0008. Also mode 01 with in_dat=15 -> 16'hFFFF.
- Backpressure: send 2, 7, 9 with out_ready=0 for 3 cycles after the first accept. Check in_ready=0 and out_result held at 16'h0004 throughout. Then release out_ready=1 -> 16'h0080 and 16'h0200 follow back-to-back, with no loss and no duplication.
- Out-of-range with RESULT_WID=10: in_dat=12 in mode 01 -> out_result=10'h000, out_err=1, err_cnt=1. Then in_dat=9 in mode 00 -> out_result=10'h200, out_err=0, err_cnt stays 1.
- Counter saturation and clear with CNT_WID=2: five out-of-range accepts -> err_cnt=3. Then err_clr in the same cycle as a sixth out-of-range accept -> err_cnt=0.
- Reset mid-transfer: hold a result with out_ready=0, then pulse rst for 1 cycle -> out_valid=0 the next cycle. The held result is never handed off, and a new accept afterwards decodes correctly.

Source files
------------

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared definitions for the registered one-hot decoder.
//   MODE_*          in_mode encodings (MODE_RSVD decodes as one-hot)
//   MAX_RESULT_WID  widest decoded vector decode_vec can produce
//   decode_t        decoded vector plus out-of-range flag
//   decode_vec()    decode of a zero-extended index into one-hot, thermometer or
//                   inverted one-hot, with all-zero output when out of range
package onehot_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_INV    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Upper bound on RESULT_WID for any instance; covers WID up to 8.
    localparam int unsigned MAX_RESULT_WID = 256;

    typedef struct packed {
        logic                      err;
        logic [MAX_RESULT_WID-1:0] vec;
    } decode_t;

    // Bits at or above result_wid are always zero. An index outside the
    // result width yields err=1 and an all-zero vector in every mode.
    function automatic decode_t decode_vec(input logic [31:0] idx,
                                           input logic [1:0]  mode,
                                           input int unsigned result_wid);
        decode_t res;
        res.vec = '0;
        res.err = (idx >= result_wid);
        if (!res.err) begin
            for (int unsigned i = 0; i < MAX_RESULT_WID; i++) begin
                if (i < result_wid) begin
                    case (mode)
                        MODE_THERM: res.vec[i] = (i <= idx);
                        MODE_INV:   res.vec[i] = (i != idx);
                        default:    res.vec[i] = (i == idx);
                    endcase
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_decode_comb.sv
// onehot_decode_comb: purely combinational index decoder.
//   idx   binary index (WID bits)
//   mode  decode mode (see onehot_pkg MODE_*)
//   vec   decoded vector (RESULT_WID bits), zero when idx is out of range
//   err   idx >= RESULT_WID
module onehot_decode_comb
    import onehot_pkg::*;
#(
    parameter int unsigned WID        = 4,
    parameter int unsigned RESULT_WID = 16
) (
    input  logic [WID-1:0]        idx,
    input  logic [1:0]            mode,
    output logic [RESULT_WID-1:0] vec,
    output logic                  err
);

    logic [31:0] idx_ext;
    decode_t     dec;
    // Bits above RESULT_WID are zero by construction and intentionally dropped.
    decode_t     unused_dec;

    always_comb begin
        idx_ext          = '0;
        idx_ext[WID-1:0] = idx;
        dec              = decode_vec(idx_ext, mode, RESULT_WID);
        vec              = dec.vec[RESULT_WID-1:0];
        err              = dec.err;
        unused_dec       = dec;
    end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: single-stage registered decoder with valid/ready flow control.
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid || out_ready
//   in_dat, in_mode       binary index and decode mode
//   out_valid/out_ready   output handshake
//   out_result, out_err   registered decoded vector and out-of-range flag
//   err_cnt, err_clr      saturating count of accepted out-of-range indices; sync clear
module onehot_decoder_pipe
    import onehot_pkg::*;
#(
    parameter int unsigned WID        = 4,
    parameter int unsigned RESULT_WID = 16,
    parameter int unsigned CNT_WID    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WID-1:0]        in_dat,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RESULT_WID-1:0] out_result,
    output logic                  out_err,
    output logic [CNT_WID-1:0]    err_cnt,
    input  logic                  err_clr
);

    localparam logic [CNT_WID-1:0] CNT_MAX = '1;

    logic [RESULT_WID-1:0] dec_vec;
    logic                  dec_err;
    logic                  accept;
    logic                  handoff;

    logic                  out_valid_q;
    logic [RESULT_WID-1:0] out_result_q;
    logic                  out_err_q;
    logic [CNT_WID-1:0]    err_cnt_q;

    onehot_decode_comb #(
        .WID        (WID),
        .RESULT_WID (RESULT_WID)
    ) u_decode (
        .idx  (in_dat),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        handoff  = out_valid_q && out_ready;
    end

    // Accept wins over handoff so back-to-back transfers keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_result_q <= dec_vec;
            out_err_q    <= dec_err;
        end else if (handoff) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Clear takes priority over a coincident out-of-range accept.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt_q <= '0;
        end else if (accept && dec_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + CNT_WID'(1);
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign err_cnt    = err_cnt_q;

endmodule
